sdram_pipeline_bridge: RTL



---
 rtl/sdram_bridge_pkg.sv | 23 ++
 rtl/sdram_skid_buffer.sv | 54 +++++
 rtl/sdram_pipeline_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_bridge_pkg.sv
// Shared types and default parameters for the SDRAM pipeline bridge.
package sdram_bridge_pkg;

  localparam int unsigned ADDR_W_DEF      = 25;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned MAX_PENDING_DEF = 8;
  localparam int unsigned TIMEOUT_DEF     = 1024;

  function automatic int unsigned pend_width(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

  localparam int unsigned PEND_W = pend_width(MAX_PENDING_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]   address;
    logic [DATA_W_DEF/8-1:0] byteenable;
    logic                    read;
    logic                    write;
    logic [DATA_W_DEF-1:0]   writedata;
  } cmd_t;

endpackage

// File: rtl/sdram_skid_buffer.sv
// Two-entry command buffer: main entry feeds the consumer, skid entry catches
// one command accepted while main is stalled. in_ready is purely registered.
module sdram_skid_buffer
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_v_q, skid_v_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, retire;

  assign in_ready  = !skid_v_q;
  assign accept    = in_valid && !skid_v_q;
  assign retire    = main_v_q && out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (retire) begin
      if (skid_v_q) begin
        main_q   <= skid_q;
        skid_v_q <= 1'b0;
      end else if (accept) begin
        main_q <= in_data;
      end else begin
        main_v_q <= 1'b0;
      end
    end else if (accept) begin
      if (main_v_q) begin
        skid_q   <= in_data;
        skid_v_q <= 1'b1;
      end else begin
        main_q   <= in_data;
        main_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_pipeline_bridge.sv
// Registered Avalon-MM stage in front of the SDRAM controller: skid-buffered
// commands, outstanding-read throttle and registered read responses.
// Optional response timeout enabled by SDRAM_PIPELINE_BRIDGE_TIMEOUT_EN.
module sdram_pipeline_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic                err
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned CmdW  = ADDR_W + BeW + 2 + DATA_W;
  localparam int unsigned PendW = pend_width(MAX_PENDING);

  if (MAX_PENDING == 0 || TIMEOUT == 0) begin : g_bad_params
    $error("sdram_pipeline_bridge: MAX_PENDING and TIMEOUT must be >= 1");
  end

  // Command layout, MSB first: address, byteenable, read, write, writedata.
  logic [CmdW-1:0] in_cmd, out_cmd;
  logic            in_ready, out_valid, out_ready;
  logic            main_read, main_write, throttle;

  assign in_cmd = {s_address, s_byteenable, s_read & ~s_write, s_write, s_writedata};

  sdram_skid_buffer #(
    .WIDTH(CmdW)
  ) u_skid (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .in_valid (s_read | s_write),
    .in_ready (in_ready),
    .in_data  (in_cmd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_cmd)
  );

  assign s_waitrequest = !in_ready;
  assign m_writedata   = out_cmd[DATA_W-1:0];
  assign main_write    = out_cmd[DATA_W];
  assign main_read     = out_cmd[DATA_W+1];
  assign m_byteenable  = out_cmd[DATA_W+2 +: BeW];
  assign m_address     = out_cmd[DATA_W+2+BeW +: ADDR_W];

  logic [PendW-1:0] pend_q, pend_d;
  logic             issue_rd, rsp_ok;

  // A throttled read blocks the head, so later writes wait behind it.
  assign throttle  = main_read && (pend_q == PendW'(MAX_PENDING));
  assign m_read    = out_valid && main_read && !throttle;
  assign m_write   = out_valid && main_write;
  assign out_ready = !m_waitrequest && !throttle;

  assign issue_rd = m_read && !m_waitrequest;
  assign rsp_ok   = m_readdatavalid && (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (issue_rd && !rsp_ok) begin
      pend_d = pend_q + PendW'(1);
    end else if (!issue_rd && rsp_ok) begin
      pend_d = pend_q - PendW'(1);
    end
  end

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_ok;
      if (rsp_ok) begin
        rsp_data_q <= m_readdata;
      end
    end
  end

  assign s_readdatavalid = rsp_valid_q;
  assign s_readdata      = rsp_data_q;

`ifdef SDRAM_PIPELINE_BRIDGE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q;

  always_comb begin
    tmo_d = tmo_q;
    if (pend_q == '0 || m_readdatavalid) begin
      tmo_d = '0;
    end else if (tmo_q != TmoW'(TIMEOUT)) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_q | (tmo_d == TmoW'(TIMEOUT));
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
